// File: rtl/jump_redirect_pkg.sv
// jump_redirect_pkg: shared widths, jump-kind and FSM state encodings for the redirect unit.
package jump_redirect_pkg;
    localparam int XLEN = 32;
    localparam int OPLEN = 7;
    localparam int STAT_W = 32;
    typedef enum logic [1:0] {JK_NONE = 2'b00, JK_BR = 2'b01, JK_JAL = 2'b10, JK_JALR = 2'b11} jump_kind_t;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_REDIRECT = 2'b01, S_FLUSH = 2'b10} state_t;
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/jump_target_calc.sv
// jump_target_calc: combinational jump target (PC- or rs1-relative, JALR bit 0 cleared) and misalign detect.
module jump_target_calc #(
    parameter int XLEN = jump_redirect_pkg::XLEN
) (
    input  logic [1:0]      jump_kind,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1data,
    output logic [XLEN-1:0] target,
    output logic            misalign
);
    import jump_redirect_pkg::*;
    logic [XLEN-1:0] jalr_sum;
    assign jalr_sum = rs1data + imm;
    assign target = (jump_kind == JK_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
    assign misalign = |target[1:0];
endmodule

// File: rtl/jump_redirect.sv
// jump_redirect: registers a fetch redirect with valid/ready, flushes wrong path, flags misaligned targets (JUMP_STAT_EN adds stat counters).
module jump_redirect #(
    parameter int XLEN = jump_redirect_pkg::XLEN,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_de,
    input  logic [1:0]      jump_kind_de,
    input  logic            jump_state_pre,
    input  logic [XLEN-1:0] pc_de,
    input  logic [XLEN-1:0] imm_de,
    input  logic [XLEN-1:0] rs1data_de,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            stall_de,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
`ifdef JUMP_STAT_EN
    ,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_not_taken,
    output logic [31:0]     stat_misalign
`endif
);
    import jump_redirect_pkg::*;
    logic [XLEN-1:0] target;
    logic misalign, eval, take;
    state_t state;
    logic [2:0] cnt;
    assign eval = valid_de && (jump_kind_de != JK_NONE);
    // an unknown comparator result must never redirect
    assign take = eval && (jump_state_pre === 1'b1);
    jump_target_calc #(.XLEN(XLEN)) u_calc (
        .jump_kind(jump_kind_de),
        .pc(pc_de),
        .imm(imm_de),
        .rs1data(rs1data_de),
        .target(target),
        .misalign(misalign)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt <= '0;
            redirect_valid <= 1'b0;
            redirect_pc <= '0;
            flush <= 1'b0;
            stall_de <= 1'b0;
            misalign_exc <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take && misalign) begin
                        misalign_exc <= 1'b1;
                        misalign_addr <= target;
                    end else if (take) begin
                        redirect_pc <= target;
                        redirect_valid <= 1'b1;
                        flush <= 1'b1;
                        stall_de <= 1'b1;
                        state <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        stall_de <= 1'b0;
                        cnt <= 3'(FLUSH_CYC);
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    cnt <= (cnt == 3'd1) ? 3'd0 : cnt - 3'd1;
                    flush <= (cnt != 3'd1);
                    state <= (cnt == 3'd1) ? S_IDLE : S_FLUSH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef JUMP_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_taken <= '0;
            stat_not_taken <= '0;
            stat_misalign <= '0;
        end else if (state == S_IDLE && eval) begin
            stat_taken <= take ? sat_inc(stat_taken) : stat_taken;
            stat_not_taken <= take ? stat_not_taken : sat_inc(stat_not_taken);
            stat_misalign <= (take && misalign) ? sat_inc(stat_misalign) : stat_misalign;
        end
    end
`endif
endmodule

// File: tb/tb_jump_redirect.sv
// tb_jump_redirect: scoreboarded bench for jump_redirect plus directed value checks (JUMP_STAT_EN checks stat counters).
module tb_jump_redirect;
    logic clk = 1'b0;
    logic rst_n;
    logic valid_de;
    logic [1:0] jump_kind_de;
    logic jump_state_pre;
    logic [31:0] pc_de, imm_de, rs1data_de;
    logic redirect_ready;
    logic redirect_valid, flush, stall_de, misalign_exc;
    logic [31:0] redirect_pc, misalign_addr;
`ifdef JUMP_STAT_EN
    logic [31:0] stat_taken, stat_not_taken, stat_misalign;
`endif
    int n_chk = 0;
    int n_fail = 0;
    localparam int FLUSH_CYC = 2;

    typedef struct packed {
        logic rv;
        logic [31:0] rpc;
        logic fl;
        logic st;
        logic mexc;
        logic [31:0] maddr;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int ms, mc;
    int m_taken, m_nt, m_mis;

    jump_redirect #(.XLEN(32), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_de(valid_de),
        .jump_kind_de(jump_kind_de),
        .jump_state_pre(jump_state_pre),
        .pc_de(pc_de),
        .imm_de(imm_de),
        .rs1data_de(rs1data_de),
        .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .stall_de(stall_de),
        .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr)
`ifdef JUMP_STAT_EN
        ,
        .stat_taken(stat_taken),
        .stat_not_taken(stat_not_taken),
        .stat_misalign(stat_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: phase 0 idle, 1 awaiting acceptance, 2 counting down flush bubbles
    always @(posedge clk) begin : model
        automatic exp_t n = e;
        automatic int s = ms;
        automatic int c = mc;
        automatic int tk = m_taken, nt = m_nt, mi = m_mis;
        automatic logic [31:0] t;
        automatic bit go = valid_de && jump_kind_de != 2'b00 && jump_state_pre === 1'b1;
        if (!rst_n) begin
            n = '0; s = 0; c = 0; tk = 0; nt = 0; mi = 0;
        end else begin
            n.mexc = 1'b0;
            if (s == 0) begin
                t = (jump_kind_de == 2'b11) ? ((rs1data_de + imm_de) & 32'hFFFF_FFFE) : pc_de + imm_de;
                if (valid_de && jump_kind_de != 2'b00) begin
                    if (go) tk++; else nt++;
                end
                if (go && t[1:0] != 2'b00) begin
                    n.mexc = 1'b1; n.maddr = t; mi++;
                end else if (go) begin
                    n.rv = 1'b1; n.rpc = t; n.fl = 1'b1; n.st = 1'b1; s = 1;
                end
            end else if (s == 1) begin
                if (redirect_ready) begin
                    n.rv = 1'b0; n.st = 1'b0; s = 2; c = FLUSH_CYC;
                end
            end else begin
                c--;
                if (c == 0) begin
                    n.fl = 1'b0; s = 0;
                end
            end
        end
        e <= n; ms <= s; mc <= c;
        m_taken <= tk; m_nt <= nt; m_mis <= mi;
        q.push_back(n);
    end

    always @(negedge clk) begin : scoreboard
        automatic exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            check("sb_redirect_valid", 32'(redirect_valid), 32'(x.rv));
            check("sb_redirect_pc", redirect_pc, x.rpc);
            check("sb_flush", 32'(flush), 32'(x.fl));
            check("sb_stall_de", 32'(stall_de), 32'(x.st));
            check("sb_misalign_exc", 32'(misalign_exc), 32'(x.mexc));
            check("sb_misalign_addr", misalign_addr, x.maddr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] kind, input logic jsp, input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        valid_de = 1'b1;
        jump_kind_de = kind;
        jump_state_pre = jsp;
        pc_de = pc;
        imm_de = imm;
        rs1data_de = rs1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid_de = 1'b0;
        jump_kind_de = 2'b00;
        jump_state_pre = 1'b0;
        pc_de = '0;
        imm_de = '0;
        rs1data_de = '0;
        redirect_ready = 1'b1;
        tick();
        tick();
        check("reset_valid", 32'(redirect_valid), 0);
        check("reset_pc", redirect_pc, 0);
        check("reset_flush", 32'(flush), 0);
        check("reset_maddr", misalign_addr, 0);
        rst_n = 1'b1;
        tick();

        // taken branch with negative offset, ready held high
        drive(2'b01, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'h0);
        tick();
        valid_de = 1'b0;
        check("br_valid", 32'(redirect_valid), 1);
        check("br_pc", redirect_pc, 32'h0F0);
        check("br_stall", 32'(stall_de), 1);
        check("br_flush0", 32'(flush), 1);
        tick();
        check("br_valid_drop", 32'(redirect_valid), 0);
        check("br_flush1", 32'(flush), 1);
        check("br_stall1", 32'(stall_de), 0);
        tick();
        check("br_flush2", 32'(flush), 1);
        tick();
        check("br_flush_end", 32'(flush), 0);

        // JALR under backpressure for three cycles
        redirect_ready = 1'b0;
        drive(2'b11, 1'b1, 32'h0, 32'h3, 32'h2001);
        tick();
        valid_de = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(redirect_valid), 1);
            check("bp_pc", redirect_pc, 32'h2004);
            check("bp_stall", 32'(stall_de), 1);
            if (i == 3) redirect_ready = 1'b1;
            tick();
        end
        check("bp_transfer", 32'(redirect_valid), 0);
        check("bp_flush", 32'(flush), 1);
        tick();
        tick();
        check("bp_idle", 32'(flush), 0);

        // wraparound target, then misaligned target
        drive(2'b10, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0);
        tick();
        valid_de = 1'b0;
        check("wrap_pc", redirect_pc, 32'h4);
        check("wrap_valid", 32'(redirect_valid), 1);
        tick();
        tick();
        tick();
        drive(2'b10, 1'b1, 32'h100, 32'h2, 32'h0);
        tick();
        valid_de = 1'b0;
        check("mis_pulse", 32'(misalign_exc), 1);
        check("mis_addr", misalign_addr, 32'h102);
        check("mis_no_redirect", 32'(redirect_valid), 0);
        check("mis_no_flush", 32'(flush), 0);
        tick();
        check("mis_pulse_end", 32'(misalign_exc), 0);
        check("mis_addr_hold", misalign_addr, 32'h102);

        // not-taken and unknown comparator results
        drive(2'b01, 1'b0, 32'h300, 32'h40, 32'h0);
        tick();
        check("nt_valid", 32'(redirect_valid), 0);
        drive(2'b01, 1'bx, 32'h300, 32'h40, 32'h0);
        tick();
        valid_de = 1'b0;
        check("x_valid", 32'(redirect_valid), 0);
        check("x_flush", 32'(flush), 0);

        // a taken JAL during FLUSH is wrong-path
        drive(2'b10, 1'b1, 32'h200, 32'h40, 32'h0);
        tick();
        valid_de = 1'b0;
        check("wp_first", redirect_pc, 32'h240);
        tick();
        drive(2'b10, 1'b1, 32'h300, 32'h10, 32'h0);
        tick();
        valid_de = 1'b0;
        check("wp_ignored", 32'(redirect_valid), 0);
        tick();
        check("wp_idle", 32'(redirect_valid), 0);
        check("wp_pc_kept", redirect_pc, 32'h240);
`ifdef JUMP_STAT_EN
        check("stat_taken", stat_taken, 5);
        check("stat_not_taken", stat_not_taken, 2);
        check("stat_misalign", stat_misalign, 1);
        check("stat_taken_model", stat_taken, 32'(m_taken));
`endif

        // reset in the middle of FLUSH, then a fresh redirect
        drive(2'b10, 1'b1, 32'h400, 32'h4, 32'h0);
        tick();
        valid_de = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_valid", 32'(redirect_valid), 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_stall", 32'(stall_de), 0);
        check("rst_maddr", misalign_addr, 0);
        drive(2'b10, 1'b1, 32'h500, 32'h8, 32'h0);
        tick();
        valid_de = 1'b0;
        check("post_rst_valid", 32'(redirect_valid), 1);
        check("post_rst_pc", redirect_pc, 32'h508);
        tick();
        tick();
        tick();
        check("post_rst_idle", 32'(flush), 0);
`ifdef JUMP_STAT_EN
        check("stat_after_rst", stat_taken, 1);
        check("stat_nt_after_rst", stat_not_taken, 32'(m_nt));
        check("stat_mis_after_rst", stat_misalign, 32'(m_mis));
`endif
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
